// File: rtl/lcg_stim_sequencer.sv
// lcg_stim_sequencer: LCG-driven stimulus source (valid/ready out)
// plus a 32-bit MISR that compacts the DUT response bus.
// Ports: clk, rst_n; start, seed_load, seed_in, num_vec (control);
// vec_data, vec_valid, vec_ready (stimulus handshake);
// resp_data, resp_valid (DUT response);
// busy, done, vec_count, signature (status).
module lcg_stim_sequencer #(
  parameter int          OUT_W     = 136,
  parameter int          RESP_W    = 159,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] SEED_RST  = 32'd107191021,
  parameter logic [31:0] LCG_A     = 32'h41C64E6D,
  parameter logic [31:0] LCG_C     = 32'h3039,
  parameter logic [31:0] MISR_POLY = 32'h04C11DB7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              seed_load,
  input  logic [31:0]       seed_in,
  input  logic [CNT_W-1:0]  num_vec,
  output logic [OUT_W-1:0]  vec_data,
  output logic              vec_valid,
  input  logic              vec_ready,
  input  logic [RESP_W-1:0] resp_data,
  input  logic              resp_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  vec_count,
  output logic [31:0]       signature
);

  localparam int NCHUNK = (OUT_W + 31) / 32;
  localparam int LOW_W  = (NCHUNK > 1) ? 32 * (NCHUNK - 1) : 1;
  localparam int LAST_W = OUT_W - 32 * (NCHUNK - 1);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_OFFER,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      lcg_s;
  logic [31:0]      lcg_nxt;
  logic [LOW_W-1:0] shadow;
  logic [OUT_W-1:0] vec_load;
  logic [KW-1:0]    chunk_k;
  logic [CNT_W-1:0] num_vec_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      fold;
  logic [31:0]      misr_nxt;

  logic idle_like;
  logic start_acc;
  logic seed_acc;
  logic fill_step;
  logic last_chunk;
  logic xfer;

  assign idle_like  = (state == S_IDLE) || (state == S_DONE);
  assign start_acc  = start && idle_like;
  assign seed_acc   = seed_load && idle_like;
  assign fill_step  = (state == S_FILL);
  assign last_chunk = (chunk_k == KW'(NCHUNK - 1));
  assign xfer       = (state == S_OFFER) && vec_valid && vec_ready;
  assign cnt_inc    = vec_count + CNT_W'(1);
  assign lcg_nxt    = lcg_s * LCG_A + LCG_C;

  // Final chunk is truncated; its upper LCG bits are dropped.
  generate
    if (NCHUNK > 1) begin : g_multi
      assign vec_load = {lcg_nxt[LAST_W-1:0], shadow};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow <= '0;
        end else if (fill_step && !last_chunk) begin
          shadow[int'(chunk_k)*32 +: 32] <= lcg_nxt;
        end
      end
    end else begin : g_single
      assign vec_load = lcg_nxt[OUT_W-1:0];
      assign shadow   = '0;
    end
  endgenerate

  // XOR-fold of all 32-bit response chunks; top chunk zero-padded.
  always_comb begin
    fold = '0;
    for (int i = 0; i < RESP_W; i++) begin
      fold[i % 32] = fold[i % 32] ^ resp_data[i];
    end
  end

  assign misr_nxt = {signature[30:0], 1'b0}
                  ^ (signature[31] ? MISR_POLY : 32'h0)
                  ^ fold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start_acc) begin
          state_nxt = (num_vec == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        busy = 1'b1;
        if (last_chunk) begin
          state_nxt = S_OFFER;
        end
      end
      S_OFFER: begin
        busy = 1'b1;
        if (xfer) begin
          state_nxt = (cnt_inc == num_vec_q) ? S_DONE : S_FILL;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcg_s     <= SEED_RST;
      chunk_k   <= '0;
      num_vec_q <= '0;
      vec_data  <= '0;
      vec_valid <= 1'b0;
      vec_count <= '0;
    end else begin
      if (seed_acc) begin
        lcg_s <= seed_in;
      end else if (fill_step) begin
        lcg_s <= lcg_nxt;
      end
      if (start_acc) begin
        num_vec_q <= num_vec;
        vec_count <= '0;
        chunk_k   <= '0;
      end
      if (fill_step) begin
        if (last_chunk) begin
          chunk_k   <= '0;
          vec_data  <= vec_load;
          vec_valid <= 1'b1;
        end else begin
          chunk_k <= chunk_k + KW'(1);
        end
      end
      if (xfer) begin
        vec_valid <= 1'b0;
        vec_count <= cnt_inc;
      end
    end
  end

  // A run start clears the signature and drops a coincident sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= '0;
    end else if (start_acc) begin
      signature <= '0;
    end else if (resp_valid) begin
      signature <= misr_nxt;
    end
  end

endmodule

// File: tb/tb_lcg_stim_sequencer.sv
// tb_lcg_stim_sequencer: directed bench for lcg_stim_sequencer
// (default build plus a 64-bit vector build).
module tb_lcg_stim_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         seed_load;
  logic [31:0]  seed_in;
  logic [31:0]  num_vec;
  logic [135:0] vec_data;
  logic         vec_valid;
  logic         vec_ready;
  logic [158:0] resp_data;
  logic         resp_valid;
  logic         busy;
  logic         done;
  logic [31:0]  vec_count;
  logic [31:0]  signature;

  logic         start64;
  logic         seed_load64;
  logic         vec_ready64;
  logic [63:0]  vec_data64;
  logic         vec_valid64;
  logic         busy64;
  logic         done64;
  logic [31:0]  vec_count64;
  logic [31:0]  signature64;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0]  ms;
  logic [135:0] v;
  logic [135:0] held;
  logic [135:0] exp2 [3];
  int           n;

  always #5 clk = ~clk;

  lcg_stim_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .seed_load(seed_load), .seed_in(seed_in),
    .num_vec(num_vec), .vec_data(vec_data),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .resp_data(resp_data), .resp_valid(resp_valid),
    .busy(busy), .done(done),
    .vec_count(vec_count), .signature(signature)
  );

  lcg_stim_sequencer #(.OUT_W(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64),
    .seed_load(seed_load64), .seed_in(seed_in),
    .num_vec(num_vec), .vec_data(vec_data64),
    .vec_valid(vec_valid64), .vec_ready(vec_ready64),
    .resp_data(resp_data), .resp_valid(resp_valid),
    .busy(busy64), .done(done64),
    .vec_count(vec_count64), .signature(signature64)
  );

  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h3039;
  endfunction

  task automatic next_vec(output logic [135:0] vo);
    logic [159:0] t;
    t = '0;
    for (int k = 0; k < 5; k++) begin
      ms = lcg(ms);
      t[32*k +: 32] = ms;
    end
    vo = t[135:0];
  endtask

  task automatic chk(input string tag,
                     input logic [159:0] obs,
                     input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int cnt);
    cnt = 0;
    while (!vec_valid && cnt < budget) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    seed_load   = 1'b0;
    seed_in     = '0;
    num_vec     = '0;
    vec_ready   = 1'b0;
    resp_data   = '0;
    resp_valid  = 1'b0;
    start64     = 1'b0;
    seed_load64 = 1'b0;
    vec_ready64 = 1'b0;
    tick();
    tick();
    chk("rst_valid", vec_valid, 0);
    chk("rst_data", vec_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", vec_count, 0);
    chk("rst_sig", signature, 0);
    rst_n = 1'b1;
    tick();

    // 64-bit build, seed 0, one vector
    seed_in     = 32'h0;
    seed_load64 = 1'b1;
    start64     = 1'b1;
    num_vec     = 32'd1;
    tick();
    seed_load64 = 1'b0;
    start64     = 1'b0;
    tick();
    chk("v64_early", vec_valid64, 0);
    tick();
    chk("v64_valid", vec_valid64, 1);
    chk("v64_data", vec_data64, 64'hD3DC167E_00003039);
    vec_ready64 = 1'b1;
    tick();
    chk("v64_done", done64, 1);
    chk("v64_count", vec_count64, 1);
    chk("v64_drop", vec_valid64, 0);

    // three vectors from the reset seed, ready tied high
    ms        = 32'd107191021;
    vec_ready = 1'b1;
    num_vec   = 32'd3;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("run_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      wait_valid(20, n);
      chk("run_lat", n, 5);
      next_vec(v);
      exp2[i] = v;
      chk("run_data", vec_data, v);
      tick();
    end
    chk("run_done", done, 1);
    chk("run_count", vec_count, 3);
    chk("run_valid", vec_valid, 0);
    chk("run_idle", busy, 0);

    // back-pressure: hold in OFFER for 10 clocks
    vec_ready = 1'b0;
    num_vec   = 32'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_clr_done", done, 0);
    wait_valid(20, n);
    chk("bp_lat", n, 5);
    next_vec(v);
    chk("bp_data", vec_data, v);
    held = vec_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_v", vec_valid, 1);
      chk("bp_hold_d", vec_data, held);
    end
    vec_ready = 1'b1;
    tick();
    chk("bp_count1", vec_count, 1);
    wait_valid(20, n);
    chk("bp_lat2", n, 5);
    next_vec(v);
    chk("bp_next", vec_data, v);
    tick();
    chk("bp_done", done, 1);
    chk("bp_count2", vec_count, 2);

    // zero-length run
    num_vec = 32'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk("z_done", done, 1);
    chk("z_count", vec_count, 0);
    chk("z_busy", busy, 0);
    tick();
    tick();
    chk("z_valid", vec_valid, 0);

    // start/seed_load mid-FILL ignored
    num_vec = 32'd1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start     = 1'b1;
    seed_load = 1'b1;
    seed_in   = 32'hDEADBEEF;
    num_vec   = 32'd0;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    wait_valid(20, n);
    chk("ign_lat", n, 2);
    next_vec(v);
    chk("ign_data", vec_data, v);
    tick();
    chk("ign_done", done, 1);
    chk("ign_count", vec_count, 1);

    // MISR
    resp_data  = 159'h1;
    resp_valid = 1'b1;
    tick();
    chk("sig_1", signature, 32'h1);
    tick();
    chk("sig_3", signature, 32'h3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sig_clr", signature, 32'h0);
    resp_data = (159'h1 << 128) | 159'h5;
    tick();
    chk("sig_fold", signature, 32'h4);
    resp_data = 159'h8000_0000;
    tick();
    chk("sig_shift", signature, 32'h8000_0008);
    resp_data = '0;
    tick();
    chk("sig_poly", signature, 32'h04C1_1DA7);
    resp_valid = 1'b0;

    // async reset mid-OFFER, then replay the first run
    vec_ready = 1'b0;
    num_vec   = 32'd3;
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(20, n);
    chk("ar_offer", vec_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", vec_valid, 0);
    chk("ar_data", vec_data, 0);
    chk("ar_busy", busy, 0);
    chk("ar_count", vec_count, 0);
    chk("ar_sig", signature, 0);
    rst_n = 1'b1;
    tick();
    vec_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid(20, n);
      chk("ar_lat", n, 5);
      chk("ar_replay", vec_data, exp2[i]);
      tick();
    end
    chk("ar_done", done, 1);
    chk("ar_cnt3", vec_count, 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
